// File: rtl/lut_pkg.sv
// Shared definitions for the activation lookup-table RAM, its run-time
// loader (lut_writer) and the datapath that reads the table.
package lut_pkg;

    // Default table geometry: 2^14 entries of 8 bits (e.g. sigmoid table).
    localparam int LUT_ADDR_WIDTH = 14;
    localparam int LUT_DATA_WIDTH = 8;

    // Loader states. CHECK is only reachable when the checksum beat is enabled.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } lut_state_t;

endpackage

// File: rtl/lut_writer.sv
// lut_writer: streams a valid/ready word sequence into the LUT RAM write
// port at consecutive addresses starting from 0, with one cycle of write
// latency, and reports completion (done) and a sticky error flag.
// Optional feature macro: LUT_WRITER_CHECKSUM_EN adds a trailing checksum
// beat whose value plus all data words must sum to zero modulo 2^DATA_WIDTH.
import lut_pkg::*;

module lut_writer #(
    parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
    parameter int DATA_WIDTH = LUT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Table depth expressed in the same width as length, so a full-depth
    // load is representable and compares cleanly.
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    lut_state_t state;
    lut_state_t next_state;

    logic [ADDR_WIDTH:0] count;
    logic [ADDR_WIDTH:0] len_q;
    logic                length_ok;
    logic                accept;
    logic                last_beat;

    assign length_ok = (length != '0) && (length <= DEPTH);
    assign accept    = s_valid && s_ready;
    assign last_beat = (count == (len_q - 1'b1));
    assign busy      = (state != IDLE);

`ifdef LUT_WRITER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] check_total;

    assign check_total = sum + s_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and stream handshake; s_ready depends only on state and abort.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = length_ok ? LOAD : FINISH;
                end
            end
            LOAD: begin
                s_ready = ~abort;
                if (abort) begin
                    next_state = FINISH;
                end else if (accept && last_beat) begin
`ifdef LUT_WRITER_CHECKSUM_EN
                    next_state = CHECK;
`else
                    next_state = FINISH;
`endif
                end
            end
`ifdef LUT_WRITER_CHECKSUM_EN
            CHECK: begin
                s_ready = ~abort;
                if (abort || accept) begin
                    next_state = FINISH;
                end
            end
`endif
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write port, beat counter, completion pulse and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            len_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
`ifdef LUT_WRITER_CHECKSUM_EN
            sum     <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length_ok) begin
                            len_q <= length;
                            count <= '0;
                            error <= 1'b0;
`ifdef LUT_WRITER_CHECKSUM_EN
                            sum   <= '0;
`endif
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        error <= 1'b1;
                    end else if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= count[ADDR_WIDTH-1:0];
                        wr_data <= s_data;
                        count   <= count + 1'b1;
`ifdef LUT_WRITER_CHECKSUM_EN
                        sum     <= sum + s_data;
`endif
                    end
                end
`ifdef LUT_WRITER_CHECKSUM_EN
                CHECK: begin
                    if (abort) begin
                        error <= 1'b1;
                    end else if (accept && (check_total != '0)) begin
                        error <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_writer.sv
// Directed self-checking bench for lut_writer (default build; the checksum
// section is compiled only with LUT_WRITER_CHECKSUM_EN defined).
`timescale 1ns/1ps

module tb_lut_writer;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   length;
    logic          abort;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          error;

    int checks;
    int fails;

    lut_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .length  (length),
        .abort   (abort),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Drive all inputs at once (called on the falling edge).
    task automatic applyStimulus(input logic st, input logic [AW:0] len, input logic val,
                                 input logic [DW-1:0] dat, input logic ab);
        start   = st;
        length  = len;
        s_valid = val;
        s_data  = dat;
        abort   = ab;
    endtask

    // Advance one rising edge and return to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check the write port in one call.
    task automatic checkWrite(input string tag, input logic en, input logic [AW-1:0] addr,
                              input logic [DW-1:0] dat);
        checkOutput({tag, "_en"}, 32'(wr_en), 32'(en));
        if (en) begin
            checkOutput({tag, "_addr"}, 32'(wr_addr), 32'(addr));
            checkOutput({tag, "_data"}, 32'(wr_data), 32'(dat));
        end
    endtask

`ifdef LUT_WRITER_CHECKSUM_EN
    // Present the checksum beat; it must never reach the RAM.
    task automatic sendChecksum(input logic [DW-1:0] value);
        applyStimulus(1'b0, '0, 1'b1, value, 1'b0);
        tick();
        checkOutput("cksum_no_write", 32'(wr_en), 32'd0);
    endtask
`endif

    initial begin
        int writes;
        int bad;
        checks = 0;
        fails  = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);

        // Reset values.
        @(negedge clk);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_wr_en",   32'(wr_en),   32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_done",    32'(done),    32'd0);
        checkOutput("rst_error",   32'(error),   32'd0);
        rst_n = 1'b1;
        tick();

        // s_valid in IDLE is ignored.
        applyStimulus(1'b0, '0, 1'b1, 8'hEE, 1'b0);
        #1;
        checkOutput("idle_s_ready", 32'(s_ready), 32'd0);
        tick();
        checkOutput("idle_no_write", 32'(wr_en), 32'd0);

        // Length 4, continuous stream.
        applyStimulus(1'b1, 15'd4, 1'b0, '0, 1'b0);
        tick();
        checkOutput("l4_busy",    32'(busy),    32'd1);
        checkOutput("l4_s_ready", 32'(s_ready), 32'd1);
        checkWrite("l4_pre", 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b1, 8'h10, 1'b0); tick(); checkWrite("l4_w0", 1'b1, 14'd0, 8'h10);
        applyStimulus(1'b0, '0, 1'b1, 8'h20, 1'b0); tick(); checkWrite("l4_w1", 1'b1, 14'd1, 8'h20);
        applyStimulus(1'b0, '0, 1'b1, 8'h30, 1'b0); tick(); checkWrite("l4_w2", 1'b1, 14'd2, 8'h30);
        applyStimulus(1'b0, '0, 1'b1, 8'h40, 1'b0); tick(); checkWrite("l4_w3", 1'b1, 14'd3, 8'h40);
        checkOutput("l4_done_early", 32'(done), 32'd0);
        checkOutput("l4_busy_end",   32'(busy), 32'd1);
`ifdef LUT_WRITER_CHECKSUM_EN
        sendChecksum(8'h60);
`endif
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("l4_done",      32'(done),    32'd1);
        checkOutput("l4_idle",      32'(busy),    32'd0);
        checkOutput("l4_error",     32'(error),   32'd0);
        checkOutput("l4_hold_addr", 32'(wr_addr), 32'd3);
        checkWrite("l4_post", 1'b0, '0, '0);
        tick();
        checkOutput("l4_done_once", 32'(done), 32'd0);

        // Length errors: zero and depth+1.
        applyStimulus(1'b1, 15'd0, 1'b1, 8'h11, 1'b0);
        tick();
        checkOutput("len0_error", 32'(error), 32'd1);
        checkOutput("len0_busy",  32'(busy),  32'd1);
        checkOutput("len0_done0", 32'(done),  32'd0);
        checkWrite("len0_w_a", 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b1, 8'h11, 1'b0);
        tick();
        checkOutput("len0_done", 32'(done), 32'd1);
        checkWrite("len0_w_b", 1'b0, '0, '0);
        applyStimulus(1'b1, 15'd16385, 1'b1, 8'h22, 1'b0);
        tick();
        checkOutput("lenbig_error", 32'(error), 32'd1);
        checkOutput("lenbig_done0", 32'(done),  32'd0);
        checkWrite("lenbig_w_a", 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("lenbig_done", 32'(done), 32'd1);
        checkOutput("lenbig_idle", 32'(busy), 32'd0);
        checkWrite("lenbig_w_b", 1'b0, '0, '0);

        // Length 3 with s_valid toggling every other cycle.
        applyStimulus(1'b1, 15'd3, 1'b0, '0, 1'b0);
        tick();
        checkOutput("l3_error_cleared", 32'(error), 32'd0);
        writes = 0;
        for (int i = 0; i < 5; i++) begin
            logic v;
            v = (i % 2 == 0);
            applyStimulus(1'b0, '0, v, 8'(8'hA0 + i), 1'b0);
            tick();
            if (wr_en) writes++;
            checkWrite($sformatf("l3_c%0d", i), v, 14'(i / 2), 8'(8'hA0 + i));
        end
`ifdef LUT_WRITER_CHECKSUM_EN
        sendChecksum(8'(8'h00 - (8'hA0 + 8'hA2 + 8'hA4)));
`endif
        applyStimulus(1'b0, '0, 1'b1, 8'hFF, 1'b0);
        tick();
        checkOutput("l3_done",   32'(done),  32'd1);
        checkOutput("l3_writes", 32'(writes), 32'd3);
        checkWrite("l3_no_extra", 1'b0, '0, '0);
        checkOutput("l3_error",  32'(error), 32'd0);

        // Abort on the second beat of a length-8 load.
        applyStimulus(1'b1, 15'd8, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 8'h55, 1'b0);
        tick();
        checkWrite("ab_w0", 1'b1, 14'd0, 8'h55);
        applyStimulus(1'b0, '0, 1'b1, 8'h66, 1'b1);
        #1;
        checkOutput("ab_s_ready", 32'(s_ready), 32'd0);
        tick();
        checkWrite("ab_no_w1", 1'b0, '0, '0);
        checkOutput("ab_error", 32'(error), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 8'h77, 1'b0);
        tick();
        checkOutput("ab_done", 32'(done), 32'd1);
        checkWrite("ab_no_w2", 1'b0, '0, '0);
        applyStimulus(1'b1, 15'd1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("ab_restart_clears", 32'(error), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 8'h99, 1'b0);
        tick();
        checkWrite("ab_r_w0", 1'b1, 14'd0, 8'h99);
`ifdef LUT_WRITER_CHECKSUM_EN
        sendChecksum(8'h67);
`endif
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("ab_r_done", 32'(done), 32'd1);

        // Full-depth load: addresses 0..0x3FFF with no wrap.
        applyStimulus(1'b1, 15'd16384, 1'b0, '0, 1'b0);
        tick();
        bad = 0;
        for (int i = 0; i < 16384; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 8'(i), 1'b0);
            tick();
            if (!wr_en || (int'(wr_addr) != i) || (wr_data != 8'(i))) bad++;
        end
        checkOutput("full_seq_bad",  32'(bad),     32'd0);
        checkOutput("full_last_adr", 32'(wr_addr), 32'h3FFF);
`ifdef LUT_WRITER_CHECKSUM_EN
        sendChecksum(8'h00);
`endif
        applyStimulus(1'b0, '0, 1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("full_no_wrap", 32'(wr_en),   32'd0);
        checkOutput("full_hold",    32'(wr_addr), 32'h3FFF);
        checkOutput("full_done",    32'(done),    32'd1);
        checkOutput("full_error",   32'(error),   32'd0);

`ifdef LUT_WRITER_CHECKSUM_EN
        // Checksum pass and fail.
        applyStimulus(1'b1, 15'd2, 1'b0, '0, 1'b0); tick();
        applyStimulus(1'b0, '0, 1'b1, 8'h01, 1'b0); tick();
        applyStimulus(1'b0, '0, 1'b1, 8'h02, 1'b0); tick();
        sendChecksum(8'hFD);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0); tick();
        checkOutput("cksum_ok_done",  32'(done),  32'd1);
        checkOutput("cksum_ok_error", 32'(error), 32'd0);
        applyStimulus(1'b1, 15'd2, 1'b0, '0, 1'b0); tick();
        applyStimulus(1'b0, '0, 1'b1, 8'h01, 1'b0); tick();
        applyStimulus(1'b0, '0, 1'b1, 8'h02, 1'b0); tick();
        sendChecksum(8'h00);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0); tick();
        checkOutput("cksum_bad_done",  32'(done),  32'd1);
        checkOutput("cksum_bad_error", 32'(error), 32'd1);
`endif

        // Reset in the middle of a load drops the pending write strobe.
        applyStimulus(1'b1, 15'd4, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 8'h5A, 1'b0);
        tick();
        checkWrite("mr_w0", 1'b1, 14'd0, 8'h5A);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_wr_en",   32'(wr_en),   32'd0);
        checkOutput("mr_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("mr_busy",    32'(busy),    32'd0);
        checkOutput("mr_s_ready", 32'(s_ready), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("mr_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lut_writer.md
# lut_writer

Streaming loader that fills an activation lookup-table memory (e.g. the 2^14 x 8 sigmoid table) at run time instead of from a hex file at elaboration. It accepts a valid/ready word stream, writes the words to consecutive addresses starting at 0 through a registered single-cycle write port, and reports completion and errors. It sits between the host/config stream and the write port of the LUT RAM; the neuron datapath reads the same RAM on the other port.

## Interface
- ADDR_WIDTH, 14, LUT address width; table depth is 2**ADDR_WIDTH
- DATA_WIDTH, 8, LUT word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- length  in  ADDR_WIDTH+1  number of words to load; sampled with start
- abort  in  1  terminate current load
- s_valid  in  1  stream word valid
- s_data  in  DATA_WIDTH  stream word
- s_ready  out  1  stream word accepted when s_valid & s_ready
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_WIDTH  RAM write address
- wr_data  out  DATA_WIDTH  RAM write data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky status; cleared by the next accepted start

## Operation
- States: IDLE, LOAD, CHECK (macro only), FINISH.
- IDLE: s_ready=0. start with 1 <= length <= 2**ADDR_WIDTH: latch length, clear count and error, go to LOAD. start with length==0 or length > 2**ADDR_WIDTH: set error, go to FINISH, no writes.
- LOAD: s_ready = ~abort. Each accepted beat writes to address count; count increments. After beat length-1 is accepted: go to CHECK (macro) or FINISH.
- Addresses run 0..length-1 and never wrap; count is ADDR_WIDTH+1 bits, so length == 2**ADDR_WIDTH ends exactly at the top address.
- abort in LOAD or CHECK: set error, go to FINISH; a beat presented in the abort cycle is not accepted and not written. abort in IDLE/FINISH is ignored.
- FINISH: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. s_valid outside LOAD/CHECK is ignored.
- Memory contents written before an abort or reset are left in place.

## Timing
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0; state IDLE.
- s_ready is combinational from state and abort only, never from s_valid.
- Write latency 1: beat accepted at edge N -> wr_en/wr_addr/wr_data valid for the cycle after N, wr_en low otherwise. wr_addr/wr_data hold last values when wr_en=0.
- Full-rate: back-to-back beats give back-to-back writes.
- done is asserted the cycle after the last write strobe (or the check beat); minimum busy time for length L without macro: L+1 cycles with continuous s_valid.
- Length error: done two cycles after start (IDLE -> FINISH -> IDLE).
- Reset asserted mid-load: outputs go to reset values asynchronously; any pending write strobe is dropped.

## Configuration
- LUT_WRITER_CHECKSUM_EN defined: after the last data beat the block enters CHECK, keeps s_ready=1, and accepts one extra beat holding a checksum: the modulo-2**DATA_WIDTH sum of all data words plus the checksum must equal 0. Mismatch sets error. The checksum beat is never written to the RAM. done follows in the next cycle.
- Not defined: no CHECK state, no accumulator, no extra beat; FINISH directly follows the last data beat.

## Structure
- Shared package lut_pkg: state enum type (IDLE/LOAD/CHECK/FINISH), default LUT_ADDR_WIDTH=14 and LUT_DATA_WIDTH=8 constants shared with the LUT RAM and its readers.
- Flat module; no sub-module needed. The target RAM is instantiated by the parent, not inside this block.

## Test plan
- Reset, then start with length=4, stream 0x10,0x20,0x30,0x40 continuously -> writes (0,0x10),(1,0x20),(2,0x30),(3,0x40) on consecutive cycles, done one cycle after last write, error=0.
- length=0 and length=2**14+1 -> no wr_en, error=1, done pulse two cycles after start.
- length=3 with s_valid toggling every other cycle -> exactly 3 writes at addresses 0..2, gaps follow the stream, no duplicate writes.
- abort during 2nd beat of length=8 with s_valid high -> only address 0 written, error=1, done pulse, next start clears error.
- length=2**14 full load -> last write at address 0x3FFF, no wrap to 0.
- With LUT_WRITER_CHECKSUM_EN: data 0x01,0x02 then checksum 0xFD -> error=0; checksum 0x00 -> error=1; checksum beat never appears on wr_en.
